// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EX/MEM and MEM/WB.
//
// Runs one req/gnt/rvalid data-bus transaction per load/store, then aligns
// and extends load data. The write-back payload (GPR and CSR) goes on to
// MEM/WB, and the pipeline is held through flow control while a bus
// transaction is outstanding.
//
// Ports
//   clk, rst             core clock, asynchronous active-high reset
//   exmem_*              instruction payload from the EX/MEM register
//   fc_stall_mem_i       downstream hold: MEM/WB is not capturing this cycle
//   mem_req_o .. mem_wdata_o, mem_gnt_i, mem_rvalid_i, mem_rdata_i
//                        data bus (req/gnt request phase, rvalid response phase)
//   mem_reg_*, mem_csr_* write-back payload to MEM/WB
//   mem_stall_o          stall request to flow control
//   mem_misalign_o       misaligned access detected
//   fsm_state            debug view of the FSM (0 IDLE, 1 WAIT_RESP, 2 DONE)
//
// Bus handshake: a request is accepted in any cycle where mem_req_o and
// mem_gnt_i are both high. Address, byte enables and write data hold steady
// until that cycle. Exactly one mem_rvalid_i follows, no earlier than the
// cycle after the grant, and it comes for loads and stores alike.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] exmem_reg_wdata_i,
    input  logic [4:0]  exmem_reg_waddr_i,
    input  logic        exmem_reg_we_i,
    input  logic [3:0]  exmem_mem_op_i,
    input  logic [31:0] exmem_mem_addr_i,
    input  logic [31:0] exmem_mem_wdata_i,
    input  logic [31:0] exmem_csr_wdata_i,
    input  logic [11:0] exmem_csr_waddr_i,
    input  logic        exmem_csr_we_i,
    input  logic        fc_stall_mem_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] mem_reg_wdata_o,
    output logic [4:0]  mem_reg_waddr_o,
    output logic        mem_reg_we_o,
    output logic [31:0] mem_csr_wdata_o,
    output logic [11:0] mem_csr_waddr_o,
    output logic        mem_csr_we_o,
    output logic        mem_stall_o,
    output logic        mem_misalign_o,
    output logic [1:0]  fsm_state
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RESP = 2'd1,
        DONE      = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] rdata_q;

    logic        is_load;
    logic        is_store;
    logic        misalign;
    logic        go;
    logic [1:0]  off;

    assign off      = exmem_mem_addr_i[1:0];
    assign is_load  = (exmem_mem_op_i >= OP_LB) && (exmem_mem_op_i <= OP_LHU);
    assign is_store = (exmem_mem_op_i >= OP_SB) && (exmem_mem_op_i <= OP_SW);

    always_comb begin
        misalign = 1'b0;
        case (exmem_mem_op_i)
            OP_LH, OP_LHU, OP_SH: misalign = off[0];
            OP_LW, OP_SW:         misalign = (off != 2'b00);
            default:              misalign = 1'b0;
        endcase
    end

    assign go = (is_load || is_store) && !misalign;

    // The transaction state is registered. The request and stall stay
    // combinational on go, so a request goes out in the same cycle the
    // instruction arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rdata_q <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (go && mem_gnt_i) state <= WAIT_RESP;
                end
                WAIT_RESP: begin
                    if (mem_rvalid_i) begin
                        rdata_q <= mem_rdata_i;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (!fc_stall_mem_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign fsm_state   = state;
    assign mem_req_o   = !rst && (state == IDLE) && go;
    assign mem_stall_o = !rst && (((state == IDLE) && go) || (state == WAIT_RESP));

    // Store lane placement. Sub-word data is replicated across every lane,
    // so the byte enables alone select where it lands.
    always_comb begin
        mem_be_o    = 4'b0000;
        mem_wdata_o = exmem_mem_wdata_i;
        case (exmem_mem_op_i)
            OP_SB: begin
                mem_wdata_o = {4{exmem_mem_wdata_i[7:0]}};
                mem_be_o    = 4'b0001 << off;
            end
            OP_SH: begin
                mem_wdata_o = {2{exmem_mem_wdata_i[15:0]}};
                mem_be_o    = off[1] ? 4'b1100 : 4'b0011;
            end
            OP_SW: mem_be_o = 4'b1111;
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: mem_be_o = 4'b1111;
            default: mem_be_o = 4'b0000;
        endcase
    end

    assign mem_we_o   = is_store;
    assign mem_addr_o = {exmem_mem_addr_i[31:2], 2'b00};

    // Load extraction from the captured response word.
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    always_comb begin
        ld_byte = 8'd0;
        case (off)
            2'd0: ld_byte = rdata_q[7:0];
            2'd1: ld_byte = rdata_q[15:8];
            2'd2: ld_byte = rdata_q[23:16];
            2'd3: ld_byte = rdata_q[31:24];
            default: ld_byte = 8'd0;
        endcase
    end

    assign ld_half = off[1] ? rdata_q[31:16] : rdata_q[15:0];

    always_comb begin
        ld_data = rdata_q;
        case (exmem_mem_op_i)
            OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_data = {24'd0, ld_byte};
            OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_data = {16'd0, ld_half};
            default: ld_data = rdata_q;
        endcase
    end

    // Before DONE a load keeps MEM/WB held by the stall, so only the DONE
    // cycle needs the extracted value.
    assign mem_reg_wdata_o = (is_load && (state == DONE)) ? ld_data : exmem_reg_wdata_i;
    assign mem_reg_waddr_o = exmem_reg_waddr_i;
    assign mem_reg_we_o    = exmem_reg_we_i && !misalign;
    assign mem_csr_wdata_o = exmem_csr_wdata_i;
    assign mem_csr_waddr_o = exmem_csr_waddr_i;
    assign mem_csr_we_o    = exmem_csr_we_i && !misalign;
    assign mem_misalign_o  = misalign;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] reg_wdata;
  logic [4:0]  reg_waddr;
  logic        reg_we;
  logic [3:0]  op;
  logic [31:0] addr;
  logic [31:0] st_data;
  logic [31:0] csr_wdata;
  logic [11:0] csr_waddr;
  logic        csr_we;
  logic        fc_stall;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] wb_wdata;
  logic [4:0]  wb_waddr;
  logic        wb_we;
  logic [31:0] wb_csr_wdata;
  logic [11:0] wb_csr_waddr;
  logic        wb_csr_we;
  logic        stall;
  logic        misalign;
  logic [1:0]  fsm_state;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  mem_stage dut (
    .clk               (clk),
    .rst               (rst),
    .exmem_reg_wdata_i (reg_wdata),
    .exmem_reg_waddr_i (reg_waddr),
    .exmem_reg_we_i    (reg_we),
    .exmem_mem_op_i    (op),
    .exmem_mem_addr_i  (addr),
    .exmem_mem_wdata_i (st_data),
    .exmem_csr_wdata_i (csr_wdata),
    .exmem_csr_waddr_i (csr_waddr),
    .exmem_csr_we_i    (csr_we),
    .fc_stall_mem_i    (fc_stall),
    .mem_req_o         (mem_req),
    .mem_we_o          (mem_we),
    .mem_be_o          (mem_be),
    .mem_addr_o        (mem_addr),
    .mem_wdata_o       (mem_wdata),
    .mem_gnt_i         (gnt),
    .mem_rvalid_i      (rvalid),
    .mem_rdata_i       (rdata),
    .mem_reg_wdata_o   (wb_wdata),
    .mem_reg_waddr_o   (wb_waddr),
    .mem_reg_we_o      (wb_we),
    .mem_csr_wdata_o   (wb_csr_wdata),
    .mem_csr_waddr_o   (wb_csr_waddr),
    .mem_csr_we_o      (wb_csr_we),
    .mem_stall_o       (stall),
    .mem_misalign_o    (misalign),
    .fsm_state         (fsm_state)
  );

  // ---------------- behavioural model ----------------
  // Transaction view: a request is either not yet granted, granted and
  // awaiting its response, or answered with data waiting for MEM/WB.
  logic        m_granted;
  logic        m_have;
  logic [31:0] m_data;

  function automatic bit f_is_load(input logic [3:0] o);
    return (o >= 4'd1) && (o <= 4'd5);
  endfunction

  function automatic bit f_is_store(input logic [3:0] o);
    return (o >= 4'd6) && (o <= 4'd8);
  endfunction

  function automatic bit f_misalign(input logic [3:0] o, input logic [31:0] a);
    int unsigned lo = a % 4;
    if (o == 4'd2 || o == 4'd5 || o == 4'd7) return (lo % 2) != 0;
    if (o == 4'd3 || o == 4'd8) return lo != 0;
    return 1'b0;
  endfunction

  function automatic bit f_go(input logic [3:0] o, input logic [31:0] a);
    return (f_is_load(o) || f_is_store(o)) && !f_misalign(o, a);
  endfunction

  function automatic logic [31:0] f_load(input logic [3:0] o, input logic [31:0] a,
                                         input logic [31:0] d);
    int unsigned lo = a % 4;
    logic [31:0] b = (d >> (8 * lo)) & 32'hFF;
    logic [31:0] h = (d >> (16 * (lo / 2))) & 32'hFFFF;
    case (o)
      4'd1: return (b >= 32'd128) ? b + 32'hFFFFFF00 : b;
      4'd4: return b;
      4'd2: return (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
      4'd5: return h;
      default: return d;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_granted <= 1'b0;
      m_have    <= 1'b0;
      m_data    <= 32'd0;
    end else if (m_have) begin
      if (!fc_stall) m_have <= 1'b0;
    end else if (m_granted) begin
      if (rvalid) begin
        m_have    <= 1'b1;
        m_data    <= rdata;
        m_granted <= 1'b0;
      end
    end else if (f_go(op, addr) && gnt) begin
      m_granted <= 1'b1;
    end
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  int req_cnt = 0;
  int stall_cnt = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic        idle_go;
    bit          mis;
    int unsigned lo;
    mis     = f_misalign(op, addr);
    lo      = addr % 4;
    idle_go = !m_granted && !m_have && f_go(op, addr);
    e_wd    = st_data;
    e_be    = 4'd0;
    if (f_is_load(op)) e_be = 4'hF;
    if (op == 4'd6) begin
      e_be = 4'(1 << lo);
      e_wd = (st_data & 32'hFF) * 32'h01010101;
    end
    if (op == 4'd7) begin
      e_be = (lo >= 2) ? 4'hC : 4'h3;
      e_wd = (st_data & 32'hFFFF) * 32'h00010001;
    end
    if (op == 4'd8) e_be = 4'hF;
    req_cnt   += int'(mem_req);
    stall_cnt += int'(stall);
    chk("req", 32'(mem_req), 32'(!rst && idle_go));
    chk("stall", 32'(stall), 32'(!rst && (idle_go || m_granted)));
    chk("we", 32'(mem_we), 32'(f_is_store(op)));
    chk("be", 32'(mem_be), 32'(e_be));
    chk("wdata", mem_wdata, e_wd);
    chk("addr", mem_addr, addr & 32'hFFFFFFFC);
    chk("misalign", 32'(misalign), 32'(mis));
    chk("wb_we", 32'(wb_we), 32'(reg_we && !mis));
    chk("wb_waddr", 32'(wb_waddr), 32'(reg_waddr));
    chk("csr_wdata", wb_csr_wdata, csr_wdata);
    chk("csr_waddr", 32'(wb_csr_waddr), 32'(csr_waddr));
    chk("csr_we", 32'(wb_csr_we), 32'(csr_we && !mis));
    if (!f_is_load(op)) begin
      chk("wb_wdata", wb_wdata, reg_wdata);
    end else if (m_have) begin
      chk("wb_load", wb_wdata, f_load(op, addr, m_data));
      // Last DONE cycle: MEM/WB captures, so retire the directed expectation.
      if (!fc_stall && exp_q.size() > 0) chk("sb_load", wb_wdata, exp_q.pop_front());
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] d);
    op        = o;
    addr      = a;
    st_data   = d;
    reg_we    = 1'b1;
    reg_waddr = 5'd7;
    reg_wdata = 32'h0BAD0BAD;
    csr_we    = 1'b0;
  endtask

  task automatic clear_op();
    op        = 4'd0;
    addr      = 32'd0;
    st_data   = 32'd0;
    reg_we    = 1'b0;
    reg_wdata = 32'd0;
    reg_waddr = 5'd0;
  endtask

  // gd: cycles without gnt, rw: WAIT_RESP cycles without rvalid,
  // hold: DONE cycles with fc_stall high (optionally with spurious rvalid).
  task automatic bus_seq(input int gd, input int rw, input int hold, input bit spur,
                         input logic [31:0] d, input int exp_req, input int exp_stall);
    int r0 = req_cnt;
    int s0 = stall_cnt;
    gnt = 1'b0;
    rvalid = 1'b0;
    fc_stall = 1'b0;
    repeat (gd) step();
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    repeat (rw) step();
    rvalid = 1'b1;
    rdata = d;
    step();
    rvalid = 1'b0;
    rdata = 32'h5A5A5A5A;
    for (int i = 0; i < hold; i++) begin
      fc_stall = 1'b1;
      rvalid = spur;
      rdata = ~d;
      step();
    end
    fc_stall = 1'b0;
    rvalid = 1'b0;
    step();
    clear_op();
    chk("req_cycles", 32'(req_cnt - r0), 32'(exp_req));
    chk("stall_cycles", 32'(stall_cnt - s0), 32'(exp_stall));
  endtask

  task automatic run_load(input logic [3:0] o, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_val, input int gd, input int rw,
                          input int hold, input bit spur);
    set_op(o, a, 32'd0);
    exp_q.push_back(exp_val);
    bus_seq(gd, rw, hold, spur, d, gd + 1, gd + rw + 2);
  endtask

  task automatic run_store(input logic [3:0] o, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] exp_wd, input logic [3:0] exp_be);
    set_op(o, a, d);
    #1;
    chk("st_wdata", mem_wdata, exp_wd);
    chk("st_be", 32'(mem_be), 32'(exp_be));
    chk("st_we", 32'(mem_we), 32'd1);
    bus_seq(0, 0, 0, 1'b0, 32'h0, 1, 2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    clear_op();
    csr_wdata = 32'd0;
    csr_waddr = 12'd0;
    csr_we    = 1'b0;
    fc_stall  = 1'b0;
    gnt       = 1'b0;
    rvalid    = 1'b0;
    rdata     = 32'd0;
    fork
      forever begin
        @(negedge clk);
        compare_cycle();
      end
    join_none

    repeat (3) step();
    chk("rst_state", 32'(fsm_state), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    rst = 1'b0;
    step();

    // Non-memory ops: op 0 and an out-of-range op are pure pass-through.
    reg_wdata = 32'h11112222; reg_waddr = 5'd3; reg_we = 1'b1;
    csr_wdata = 32'hC5C5C5C5; csr_waddr = 12'h305; csr_we = 1'b1;
    #1;
    chk("nop_wdata", wb_wdata, 32'h11112222);
    step();
    op = 4'd12;
    #1;
    chk("op12_stall", 32'(stall), 32'd0);
    step();
    clear_op();
    csr_we = 1'b0;
    step();

    // Loads.
    run_load(4'd3, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 1'b0);
    run_load(4'd1, 32'h103, 32'h80123456, 32'hFFFFFF80, 0, 0, 0, 1'b0);
    run_load(4'd4, 32'h103, 32'h80123456, 32'h00000080, 0, 0, 0, 1'b0);
    run_load(4'd2, 32'h102, 32'h7FFF1234, 32'h00007FFF, 0, 0, 0, 1'b0);
    run_load(4'd2, 32'h100, 32'h7FFF9234, 32'hFFFF9234, 0, 0, 0, 1'b0);
    run_load(4'd5, 32'h102, 32'h8001ABCD, 32'h00008001, 0, 0, 0, 1'b0);

    // Stores.
    run_store(4'd6, 32'h201, 32'h000000AB, 32'hABABABAB, 4'b0010);
    run_store(4'd7, 32'h202, 32'h00001234, 32'h12341234, 4'b1100);
    run_store(4'd8, 32'h204, 32'hA5A55A5A, 32'hA5A55A5A, 4'b1111);

    // Slow bus: gnt after 3 idle cycles, rvalid two cycles after gnt.
    run_load(4'd3, 32'h400, 32'h01020304, 32'h01020304, 3, 1, 0, 1'b0);

    // DONE held by downstream for 3 cycles with spurious rvalid.
    run_load(4'd1, 32'h501, 32'h0000F000, 32'hFFFFFFF0, 0, 0, 3, 1'b1);

    // Misaligned word load: no request, writes suppressed.
    set_op(4'd3, 32'h102, 32'd0);
    csr_we = 1'b1;
    #1;
    chk("mis_flag", 32'(misalign), 32'd1);
    chk("mis_req", 32'(mem_req), 32'd0);
    chk("mis_reg_we", 32'(wb_we), 32'd0);
    chk("mis_stall", 32'(stall), 32'd0);
    chk("mis_csr_we", 32'(wb_csr_we), 32'd0);
    step();
    clear_op();
    csr_we = 1'b0;
    step();

    // Reset while waiting for the response.
    set_op(4'd3, 32'h300, 32'd0);
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    @(negedge clk);
    chk("wait_stall", 32'(stall), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_req", 32'(mem_req), 32'd0);
    chk("midrst_stall", 32'(stall), 32'd0);
    chk("midrst_state", 32'(fsm_state), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    clear_op();
    step();
    run_load(4'd3, 32'h300, 32'hCAFEF00D, 32'hCAFEF00D, 0, 0, 0, 1'b0);

    step();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
